// File: rtl/trsio_boot_pkg.sv
// Shared definitions for the boot pROM path.
//   - Default boot window placement and pROM address width.
//   - pROM read latency, shared with every pROM consumer.
//   - Reader FSM state encoding.
package trsio_boot_pkg;

    localparam logic [15:0] ROM_BASE_DEFAULT = 16'h0000;
    localparam int unsigned ROM_AW_DEFAULT   = 8;

    // Clocks from address presented (ce) to byte on dout (registered-output pROM).
    localparam int unsigned ROM_LAT = 2;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAddr = 3'd1,
        StPipe = 3'd2,
        StCapt = 3'd3,
        StHold = 3'd4
    } boot_state_e;

endpackage

// File: rtl/boot_rom_window_dec.sv
// Boot window decoder: reports whether a Z80 address falls inside the pROM window and the
// byte offset into the pROM. Purely combinational; also used by the bus mux.
//   addr_i    Z80 address
//   hit_o     address lies in [ROM_BASE, ROM_BASE + 2**ROM_AW)
//   offset_o  pROM address (addr_i - ROM_BASE, truncated to ROM_AW bits)
module boot_rom_window_dec
    import trsio_boot_pkg::*;
#(
    parameter logic [15:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter int unsigned ROM_AW   = ROM_AW_DEFAULT
) (
    input  logic [15:0]       addr_i,
    output logic              hit_o,
    output logic [ROM_AW-1:0] offset_o
);

    localparam logic [16:0] WIN_SIZE = 17'd1 << ROM_AW;

    // 17-bit subtraction: an address below ROM_BASE wraps to a huge value and never hits.
    logic [16:0] diff;

    assign diff     = {1'b0, addr_i} - {1'b0, ROM_BASE};
    assign hit_o    = diff < WIN_SIZE;
    assign offset_o = diff[ROM_AW-1:0];

endmodule

// File: rtl/boot_rom_bus_reader.sv
// Boot pROM bus reader: converts synchronized Z80 memory reads in the boot window into pROM
// accesses, stalls the Z80 with WAIT across the two-stage pROM pipeline, then drives the byte
// until the read cycle ends. Owns the boot-overlay flag.
//   clk_i             system clock
//   rst_ni            asynchronous active-low reset
//   bus_addr_i        synchronized Z80 address
//   bus_mem_rd_i      synchronized MREQ&RD level
//   overlay_off_i     one-cycle pulse, unmaps the boot window until next reset
//   rom_ad_o          pROM address
//   rom_ce_o          pROM clock enable (address sample), high only in StAddr
//   rom_oce_o         pROM output-register enable, high only in StPipe
//   rom_reset_o       pROM synchronous reset, active high
//   rom_dout_i        pROM data
//   bus_data_out_o    byte for the Z80 data bus
//   bus_drive_o       data-bus output enable
//   bus_wait_o        Z80 WAIT request
//   overlay_active_o  boot window is mapped
module boot_rom_bus_reader
    import trsio_boot_pkg::*;
#(
    parameter logic [15:0] ROM_BASE = ROM_BASE_DEFAULT,
    parameter int unsigned ROM_AW   = ROM_AW_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [15:0]       bus_addr_i,
    input  logic              bus_mem_rd_i,
    input  logic              overlay_off_i,
    output logic [ROM_AW-1:0] rom_ad_o,
    output logic              rom_ce_o,
    output logic              rom_oce_o,
    output logic              rom_reset_o,
    input  logic [7:0]        rom_dout_i,
    output logic [7:0]        bus_data_out_o,
    output logic              bus_drive_o,
    output logic              bus_wait_o,
    output logic              overlay_active_o
);

    boot_state_e       state_q;
    logic              rd_q;
    logic              abort_q;
    logic [ROM_AW-1:0] rom_ad_q;
    logic              rom_ce_q;
    logic              rom_oce_q;
    logic              rom_reset_q;
    logic [7:0]        data_q;
    logic              drive_q;
    logic              wait_q;
    logic              overlay_q;

    logic              win_hit;
    logic [ROM_AW-1:0] win_offset;
    logic              start;

    boot_rom_window_dec #(
        .ROM_BASE (ROM_BASE),
        .ROM_AW   (ROM_AW)
    ) u_window_dec (
        .addr_i   (bus_addr_i),
        .hit_o    (win_hit),
        .offset_o (win_offset)
    );

    // Rising edge of the read level, gated by the overlay and the window.
    assign start = bus_mem_rd_i & ~rd_q & overlay_q & win_hit;

    // Read-edge history, pROM reset stretch and the overlay flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q        <= 1'b0;
            rom_reset_q <= 1'b1;
            overlay_q   <= 1'b1;
        end else begin
            rd_q        <= bus_mem_rd_i;
            // Holds the pROM in reset until the first edge after release.
            rom_reset_q <= 1'b0;
            if (overlay_off_i) begin
                overlay_q <= 1'b0;
            end
        end
    end

    // Access sequencer: all bus and pROM controls are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            abort_q   <= 1'b0;
            rom_ad_q  <= '0;
            rom_ce_q  <= 1'b0;
            rom_oce_q <= 1'b0;
            data_q    <= 8'h00;
            drive_q   <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            // ce and oce are single-cycle strobes, each set on entry to its state.
            rom_ce_q  <= 1'b0;
            rom_oce_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        rom_ad_q <= win_offset;
                        rom_ce_q <= 1'b1;
                        wait_q   <= 1'b1;
                        abort_q  <= 1'b0;
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    rom_oce_q <= 1'b1;
                    state_q   <= StPipe;
                    if (!bus_mem_rd_i) begin
                        wait_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end
                end
                StPipe: begin
                    // The pipeline is allowed to finish even after an abort.
                    state_q <= StCapt;
                    if (!bus_mem_rd_i) begin
                        wait_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end
                end
                StCapt: begin
                    wait_q <= 1'b0;
                    if (bus_mem_rd_i && !abort_q) begin
                        data_q  <= rom_dout_i;
                        drive_q <= 1'b1;
                        state_q <= StHold;
                    end else begin
                        // Aborted read: the byte is discarded and the bus is never driven.
                        state_q <= StIdle;
                    end
                end
                StHold: begin
                    if (!bus_mem_rd_i) begin
                        drive_q <= 1'b0;
                        data_q  <= 8'h00;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rom_ad_o         = rom_ad_q;
    assign rom_ce_o         = rom_ce_q;
    assign rom_oce_o        = rom_oce_q;
    assign rom_reset_o      = rom_reset_q;
    assign bus_data_out_o   = data_q;
    assign bus_drive_o      = drive_q;
    assign bus_wait_o       = wait_q;
    assign overlay_active_o = overlay_q;

endmodule

// File: tb/tb_boot_rom_bus_reader.sv
// Bench for boot_rom_bus_reader: two instances (window at 16'h0000 and at 16'h3000) sharing
// the Z80 bus, each with its own behavioural registered-output pROM. Expected bytes are
// pushed to a scoreboard when a read is issued and popped when the DUT drives the bus.
module tb_boot_rom_bus_reader;
    import trsio_boot_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_addr;
    logic        bus_mem_rd;
    logic        overlay_off;

    logic [7:0] rom_ad0, rom_ad1, rom_dout0, rom_dout1, data0, data1;
    logic       rom_ce0, rom_ce1, rom_oce0, rom_oce1, rom_reset0, rom_reset1;
    logic       drive0, drive1, wait0, wait1, ovl0, ovl1;

    logic [7:0] rom_img [256];
    logic [7:0] p0_r1, p1_r1;
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ce_cnt0  = 0;
    int         ce_cnt1  = 0;
    int         overlap  = 0;

    boot_rom_bus_reader #(.ROM_BASE(16'h0000), .ROM_AW(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus_addr_i(bus_addr), .bus_mem_rd_i(bus_mem_rd),
        .overlay_off_i(overlay_off), .rom_ad_o(rom_ad0), .rom_ce_o(rom_ce0),
        .rom_oce_o(rom_oce0), .rom_reset_o(rom_reset0), .rom_dout_i(rom_dout0),
        .bus_data_out_o(data0), .bus_drive_o(drive0), .bus_wait_o(wait0),
        .overlay_active_o(ovl0)
    );

    boot_rom_bus_reader #(.ROM_BASE(16'h3000), .ROM_AW(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus_addr_i(bus_addr), .bus_mem_rd_i(bus_mem_rd),
        .overlay_off_i(overlay_off), .rom_ad_o(rom_ad1), .rom_ce_o(rom_ce1),
        .rom_oce_o(rom_oce1), .rom_reset_o(rom_reset1), .rom_dout_i(rom_dout1),
        .bus_data_out_o(data1), .bus_drive_o(drive1), .bus_wait_o(wait1),
        .overlay_active_o(ovl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output pROM models: ce samples the address, oce loads the output register.
    always @(posedge clk) begin
        if (rom_reset0) begin
            p0_r1 <= 8'h00; rom_dout0 <= 8'h00;
        end else begin
            if (rom_ce0)  p0_r1 <= rom_img[rom_ad0];
            if (rom_oce0) rom_dout0 <= p0_r1;
        end
    end

    always @(posedge clk) begin
        if (rom_reset1) begin
            p1_r1 <= 8'h00; rom_dout1 <= 8'h00;
        end else begin
            if (rom_ce1)  p1_r1 <= rom_img[rom_ad1];
            if (rom_oce1) rom_dout1 <= p1_r1;
        end
    end

    always @(posedge clk) begin
        if (rom_ce0) ce_cnt0 <= ce_cnt0 + 1;
        if (rom_ce1) ce_cnt1 <= ce_cnt1 + 1;
        if ((rom_ce0 && rom_oce0) || (rom_ce1 && rom_oce1)) overlap <= overlap + 1;
    end

    function automatic logic sel_wait(input int s);
        return (s == 0) ? wait0 : wait1;
    endfunction

    function automatic logic sel_drive(input int s);
        return (s == 0) ? drive0 : drive1;
    endfunction

    function automatic logic [7:0] sel_data(input int s);
        return (s == 0) ? data0 : data1;
    endfunction

    // Raises the read at the current negedge and watches up to 6 cycles for bus_drive.
    task automatic run_read(input logic [15:0] addr, input int s, output int wait_cnt,
                            output int lat, output logic [7:0] data, output logic drove);
        bus_addr   = addr;
        bus_mem_rd = 1'b1;
        wait_cnt = 0; lat = 0; data = 8'h00; drove = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (sel_wait(s)) wait_cnt++;
            if (sel_drive(s)) begin
                drove = 1'b1; lat = i; data = sel_data(s);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_addr = 16'h0000; bus_mem_rd = 1'b0; overlay_off = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wait0, drive0, rom_ce0, rom_oce0} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                               {wait0, drive0, rom_ce0, rom_oce0});
        end
        n_checks++;
        if ({rom_ad0, data0} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_ad_data: got %h expected 0000", {rom_ad0, data0});
        end
        n_checks++;
        if ({ovl0, rom_reset0} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ovl_romrst: got %b expected 11", {ovl0, rom_reset0});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rom_reset0 !== 1'b1) begin
            n_fail++; $display("FAIL rom_reset_release: got %b expected 1", rom_reset0);
        end
        @(negedge clk);
        n_checks++;
        if (rom_reset0 !== 1'b0) begin
            n_fail++; $display("FAIL rom_reset_after: got %b expected 0", rom_reset0);
        end
    endtask

    task automatic test_read_basic();
        int wc, lat, c0; logic [7:0] d, e; logic dr;
        c0 = ce_cnt0;
        exp_q.push_back(rom_img[8'h00]);
        run_read(16'h0000, 0, wc, lat, d, dr);
        e = exp_q.pop_front();
        n_checks++;
        if (!dr || d !== e) begin
            n_fail++; $display("FAIL read0_data: drove=%b got %h expected %h", dr, d, e);
        end
        n_checks++;
        if (lat != 4 || wc != 3) begin
            n_fail++; $display("FAIL read0_timing: lat=%0d wait=%0d expected lat=4 wait=3",
                               lat, wc);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (!drive0 || data0 !== e) begin
                n_fail++; $display("FAIL read0_hold: drive=%b data=%h expected 1 %h",
                                   drive0, data0, e);
            end
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (drive0 !== 1'b0) begin
            n_fail++; $display("FAIL read0_release: drive=%b expected 0", drive0);
        end
        n_checks++;
        if (ce_cnt0 - c0 != 1) begin
            n_fail++; $display("FAIL read0_ce_count: got %0d expected 1", ce_cnt0 - c0);
        end
    endtask

    task automatic test_back_to_back();
        int wc, lat, c0; logic [7:0] d, e; logic dr;
        logic [15:0] addrs [2];
        addrs[0] = 16'h0001; addrs[1] = 16'h0002;
        for (int k = 0; k < 2; k++) begin
            c0 = ce_cnt0;
            exp_q.push_back(rom_img[addrs[k][7:0]]);
            run_read(addrs[k], 0, wc, lat, d, dr);
            e = exp_q.pop_front();
            n_checks++;
            if (!dr || d !== e || lat != 4) begin
                n_fail++; $display("FAIL b2b_read%0d: drove=%b got %h lat=%0d expected %h lat=4",
                                   k, dr, d, lat, e);
            end
            bus_mem_rd = 1'b0;
            @(negedge clk);
            n_checks++;
            if (drive0 !== 1'b0 || ce_cnt0 - c0 != 1) begin
                n_fail++; $display("FAIL b2b_end%0d: drive=%b ce=%0d expected 0 1",
                                   k, drive0, ce_cnt0 - c0);
            end
        end
    endtask

    task automatic test_window();
        int wc, lat; logic [7:0] d, e; logic dr;
        logic [15:0] miss [2];
        miss[0] = 16'h2FFF; miss[1] = 16'h3100;
        for (int k = 0; k < 2; k++) begin
            run_read(miss[k], 1, wc, lat, d, dr);
            n_checks++;
            if (dr || wc != 0) begin
                n_fail++; $display("FAIL window_miss_%h: drove=%b wait=%0d expected 0 0",
                                   miss[k], dr, wc);
            end
            bus_mem_rd = 1'b0;
            @(negedge clk);
        end
        exp_q.push_back(rom_img[8'hFF]);
        run_read(16'h30FF, 1, wc, lat, d, dr);
        e = exp_q.pop_front();
        n_checks++;
        if (!dr || d !== e || lat != 4 || wc != 3) begin
            n_fail++; $display("FAIL window_hit: drove=%b got %h lat=%0d wait=%0d expected %h 4 3",
                               dr, d, lat, wc, e);
        end
        n_checks++;
        if (rom_ad1 !== 8'hFF) begin
            n_fail++; $display("FAIL window_rom_ad: got %h expected ff", rom_ad1);
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (drive1 !== 1'b0) begin
            n_fail++; $display("FAIL window_release: drive=%b expected 0", drive1);
        end
    endtask

    task automatic test_abort();
        int idle_at; logic drove_any;
        bus_addr = 16'h0003; bus_mem_rd = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut0.state_q !== StPipe || wait0 !== 1'b1) begin
            n_fail++; $display("FAIL abort_setup: state=%0d wait=%b expected %0d 1",
                               dut0.state_q, wait0, StPipe);
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wait0 !== 1'b0) begin
            n_fail++; $display("FAIL abort_wait_drop: got %b expected 0", wait0);
        end
        idle_at = -1; drove_any = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (dut0.state_q == StIdle && idle_at < 0) idle_at = k;
            if (drive0) drove_any = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (drove_any !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_drive: drove=%b expected 0", drove_any);
        end
        n_checks++;
        if (idle_at < 1 || idle_at > 3) begin
            n_fail++; $display("FAIL abort_idle: reached idle at %0d expected 1..3", idle_at);
        end
    endtask

    task automatic test_reset_mid_capt();
        int wc, lat; logic [7:0] d, e; logic dr;
        bus_addr = 16'h0004; bus_mem_rd = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut0.state_q !== StCapt) begin
            n_fail++; $display("FAIL rst_capt_setup: state=%0d expected %0d",
                               dut0.state_q, StCapt);
        end
        #1 rst_n = 1'b0; bus_mem_rd = 1'b0;
        #1;
        n_checks++;
        if ({wait0, drive0, rom_ce0, rom_oce0, rom_ad0, data0} !== 20'h0) begin
            n_fail++; $display("FAIL rst_async_outputs: got %h expected 0",
                               {wait0, drive0, rom_ce0, rom_oce0, rom_ad0, data0});
        end
        n_checks++;
        if ({ovl0, rom_reset0} !== 2'b11) begin
            n_fail++; $display("FAIL rst_async_ovl: got %b expected 11", {ovl0, rom_reset0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rom_reset0 !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_romrst_hold: got %b expected 1", rom_reset0);
        end
        @(negedge clk);
        n_checks++;
        if (rom_reset0 !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_romrst_clear: got %b expected 0", rom_reset0);
        end
        exp_q.push_back(rom_img[8'h04]);
        run_read(16'h0004, 0, wc, lat, d, dr);
        e = exp_q.pop_front();
        n_checks++;
        if (!dr || d !== e || lat != 4) begin
            n_fail++; $display("FAIL rst_mid_next_read: drove=%b got %h lat=%0d expected %h 4",
                               dr, d, lat, e);
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overlay_off();
        int wc, lat, c0; logic [7:0] d, e; logic dr;
        exp_q.push_back(rom_img[8'h05]);
        run_read(16'h0005, 0, wc, lat, d, dr);
        e = exp_q.pop_front();
        n_checks++;
        if (!dr || d !== e) begin
            n_fail++; $display("FAIL ovl_read: drove=%b got %h expected %h", dr, d, e);
        end
        overlay_off = 1'b1;
        @(negedge clk);
        overlay_off = 1'b0;
        n_checks++;
        if (ovl0 !== 1'b0 || drive0 !== 1'b1 || data0 !== e) begin
            n_fail++; $display("FAIL ovl_hold: ovl=%b drive=%b data=%h expected 0 1 %h",
                               ovl0, drive0, data0, e);
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (drive0 !== 1'b0) begin
            n_fail++; $display("FAIL ovl_release: drive=%b expected 0", drive0);
        end
        c0 = ce_cnt0;
        run_read(16'h0005, 0, wc, lat, d, dr);
        n_checks++;
        if (dr || wc != 0 || ce_cnt0 != c0 || ovl0 !== 1'b0) begin
            n_fail++; $display("FAIL ovl_blocked: drove=%b wait=%0d ce=%0d ovl=%b expected 0 0 0 0",
                               dr, wc, ce_cnt0 - c0, ovl0);
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overlay_restore();
        int wc, lat; logic [7:0] d, e; logic dr;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ovl0 !== 1'b1) begin
            n_fail++; $display("FAIL ovl_restore: got %b expected 1", ovl0);
        end
        exp_q.push_back(rom_img[8'h01]);
        run_read(16'h0001, 0, wc, lat, d, dr);
        e = exp_q.pop_front();
        n_checks++;
        if (!dr || d !== e) begin
            n_fail++; $display("FAIL ovl_restore_read: drove=%b got %h expected %h", dr, d, e);
        end
        bus_mem_rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom_img[i] = 8'(i) ^ 8'hA5;
        rom_img[0] = 8'hFE; rom_img[1] = 8'h3E; rom_img[2] = 8'hFF;
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_window();
        test_abort();
        test_reset_mid_capt();
        test_overlay_off();
        test_overlay_restore();
        n_checks++;
        if (overlap != 0) begin
            n_fail++; $display("FAIL ce_oce_overlap: got %0d expected 0", overlap);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_rom_bus_reader.md
Name: boot_rom_bus_reader

Overview:
- Downstream consumer of the 256x8 boot pROM (Gowin pROM wrapper, READ_MODE registered output, SYNC reset).
- Turns synchronized Z80 memory-read cycles inside the boot window into pROM accesses, absorbing the 2-stage pROM pipeline.
- Holds the Z80 via bus_wait until data is valid, then drives the byte onto the bus for the rest of the cycle.
- Owns the boot-overlay flag; firmware or the host clears it when the loader hands off.

Parameters:
- ROM_BASE, 16'h0000, first Z80 address of the boot window.
- ROM_AW, 8, pROM address width; window size is 2**ROM_AW bytes.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bus_addr  in  16  Z80 address, already synchronized to clk
- bus_mem_rd  in  1  level; Z80 MREQ&RD active, synchronized
- overlay_off  in  1  single-cycle pulse; disables the boot overlay
- rom_ad  out  ROM_AW  to pROM ad
- rom_ce  out  1  to pROM ce
- rom_oce  out  1  to pROM oce
- rom_reset  out  1  to pROM reset (active-high)
- rom_dout  in  8  from pROM dout
- bus_data_out  out  8  byte for the Z80 data bus
- bus_drive  out  1  data-bus output enable
- bus_wait  out  1  request Z80 WAIT
- overlay_active  out  1  boot window is mapped

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - rom_ad=0, rom_ce=0, rom_oce=0.
  - bus_data_out=0, bus_drive=0, bus_wait=0.
  - overlay_active=1.
  - rom_reset=1 while reset_n is low, and for 1 clk after release.
- Start edge: rd_q registers bus_mem_rd. start = bus_mem_rd & ~rd_q & overlay_active & (bus_addr - ROM_BASE) < 2**ROM_AW. The comparison is 17-bit unsigned, so an address below ROM_BASE never hits.
- FSM states IDLE, ADDR, PIPE, CAPT, HOLD.
  - IDLE: on start, register rom_ad = (bus_addr-ROM_BASE)[ROM_AW-1:0], assert bus_wait=1 in the same edge, go to ADDR.
  - ADDR: rom_ce=1 for this cycle only; the pROM samples the address. Go to PIPE.
  - PIPE: rom_oce=1; the pROM output register loads. Go to CAPT.
  - CAPT: bus_data_out <= rom_dout; bus_drive <= 1; bus_wait <= 0. Go to HOLD.
  - HOLD: keep bus_drive=1 and bus_data_out stable while bus_mem_rd=1. When bus_mem_rd=0: bus_drive <= 0 and go to IDLE.
- Latency, taking start as sampled on edge N:
  - bus_wait is high from N+1 to N+3.
  - bus_drive and data are valid from N+4.
  - Fixed latency of 4 clk.
- Abort: if bus_mem_rd falls in ADDR, PIPE or CAPT, finish the pROM pipeline internally but never assert bus_drive. Drop bus_wait at once, then return to IDLE.
- Back-to-back reads: a new start is recognized only in IDLE. A rising edge that arrives in HOLD is impossible (rd is still high). A read that starts the cycle after HOLD exits is served normally.
- overlay_off:
  - Clears overlay_active on the next edge.
  - If a transaction is in flight, it completes normally, including HOLD.
  - No further starts while overlay_active=0.
  - Only reset sets overlay_active again.
  - overlay_off together with start in IDLE: start wins for that one cycle, then the overlay clears.
- Outside the window, or with the overlay off: all outputs stay idle. bus_drive=0 guarantees no bus contention.
- rom_ce and rom_oce are never high at the same time, and never outside ADDR and PIPE respectively.

Decomposition:
- Shared package trsio_boot_pkg holds:
  - the FSM state enum (3-bit);
  - ROM_BASE and ROM_AW defaults;
  - the ROM_LAT=2 constant, shared by any other pROM consumer.
- One natural sub-module: boot_rom_window_dec (combinational hit/offset from bus_addr, ROM_BASE, ROM_AW), reused by the bus mux.
- The pROM itself is instantiated in the parent, not in this block.

Test Plan:
- Reset then read 16'h0000 (real pROM model) -> bus_wait high for 3 clk; bus_data_out=8'hFE with bus_drive at N+4; bus_drive drops 1 clk after bus_mem_rd falls.
- Read 16'h0001, then 16'h0002 back-to-back (1 idle cycle between) -> 8'h3E, then 8'hFF; rom_ce seen exactly once per read.
- ROM_BASE=16'h3000: read 16'h2FFF and 16'h3100 -> no bus_wait, no bus_drive. Read 16'h30FF -> rom_ad=8'hFF, correct byte returned.
- Drop bus_mem_rd in PIPE -> bus_wait falls the next clk; bus_drive never asserts; FSM in IDLE within 3 clk.
- overlay_off pulsed during HOLD of a read at 16'h0005 -> current byte delivered intact; a later read of 16'h0005 gives no response; overlay_active=0.
- Assert reset_n low mid-CAPT -> all outputs 0 asynchronously; overlay_active=1; rom_reset high through release+1 clk; next read works.
